ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit for the MIPS datapath. It sits directly upstream of the immediate extender.
- Holds the PC and issues word fetches over a request/grant/response instruction-memory interface.
- Registers each returned instruction, presents it to decode with a valid/ready handshake, and drives instr[15:0] straight to the extender's imm input.
- Branch/jump redirects come back from the next-PC logic, which consumes the extender's output.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
imem_req  out  1  fetch request
imem_addr  out  32  fetch word address (= pc), valid while imem_req=1
imem_gnt  in  1  memory accepts request this cycle (imem_req && imem_gnt = accepted)
imem_rvalid  in  1  read data valid, at least 1 cycle after accept
imem_rdata  in  32  instruction word
redirect  in  1  one-cycle pulse: flush and refetch from redirect_target
redirect_target  in  32  new PC (pc+4+ext<<2 for branches, jump target)
id_valid  out  1  id_instr/id_pc hold a valid instruction
id_ready  in  1  decode accepts (id_valid && id_ready = transfer)
id_instr  out  32  registered instruction
id_pc  out  32  address of id_instr
id_imm  out  16  id_instr[15:0], feeds extender imm

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, state=REQ, discard=0, id_valid=0, id_instr=0, id_pc=0. imem_req is 0 while reset is low.
- FSM states: REQ, WAIT. At most one outstanding fetch. The output register holds one entry.
- REQ:
  - imem_req = !redirect && (!id_valid || id_ready); imem_addr = pc.
  - On accept: pc <= pc+4, latch fetch address in fa, go WAIT.
- WAIT:
  - imem_req = 0.
  - On imem_rvalid with discard=0: id_instr <= imem_rdata, id_pc <= fa, id_valid <= 1, go REQ.
  - On imem_rvalid with discard=1: drop data, discard <= 0, go REQ.
- Output register: id_valid clears on transfer unless reloaded in the same cycle. id_instr/id_pc are stable while id_valid && !id_ready.
- Redirect (highest priority, any state):
  - pc <= redirect_target; id_valid <= 0.
  - In REQ: the request is suppressed that cycle (no accept possible).
  - In WAIT with no rvalid that cycle: discard <= 1, stay WAIT.
  - In WAIT with rvalid the same cycle: data dropped, go REQ, discard stays 0.
  - Redirect with id_valid && id_ready in the same cycle: the transfer still counts for decode; the IFU flushes regardless.
- Latency: gnt in cycle N, rvalid in N+1 gives id_valid in N+2. Next request is issued in N+2. Peak throughput is 1 instruction per 2 cycles with zero-wait memory.
- pc arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Backpressure: if id_valid && !id_ready, no new request is issued; pc holds.
- Reset asserted mid-fetch: all state is reinitialised immediately. Memory is reset by the same signal, so no stale response follows.

Optional Feature:
- Macro: IFU_ALIGN_CHECK_EN.
- Defined: adds output port fetch_err (1 bit, reset 0).
  - A redirect with redirect_target[1:0] != 0 sets fetch_err sticky, leaves pc unchanged, and enters state HALT.
  - HALT: imem_req=0, id_valid=0, any outstanding response discarded. Exit only via reset.
- Undefined: no port. redirect_target[1:0] is ignored; pc loads {redirect_target[31:2],2'b00}.

Test Plan:
- Reset release, gnt always 1, rvalid 1 cycle after accept, imem_rdata=addr -> id_pc sequence 0x3000, 0x3004, 0x3008, one id_valid every 2 cycles, id_imm=id_instr[15:0].
- id_ready held 0 for 5 cycles after first id_valid -> id_instr/id_pc stable, imem_req=0, no pc advance. Then id_ready=1 -> resumes with 0x3004.
- Redirect to 0x3100 while in WAIT, rvalid 3 cycles later -> that response dropped, next id_pc=0x3100, no id_valid for stale word.
- Redirect in the same cycle as rvalid -> stale word dropped, imem_addr=0x3100 on next request.
- Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
- IFU_ALIGN_CHECK_EN: redirect to 0x3102 -> fetch_err=1 next cycle, imem_req stays 0. Reset low clears fetch_err and restarts at 0x3000.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: groups the instruction-memory request/response channel, the
// redirect input from the next-PC logic, and the decode-side valid/ready
// output of the fetch unit. "master" is the fetch unit's view, "slave" is the
// view of the surrounding memory/decode/next-PC logic.
interface ifu_fetch_if;
  // instruction memory request/grant/response
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // flush/refetch from the next-PC logic
  logic        redirect;
  logic [31:0] redirect_target;

  // decode-side handshake and immediate feed to the extender
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [15:0] id_imm;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    input  redirect,
    input  redirect_target,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc,
    output id_imm
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    output redirect,
    output redirect_target,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc,
    input  id_imm
  );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit for the MIPS datapath.
// Holds the PC, issues one word fetch at a time over a request/grant/response
// memory interface, registers the returned instruction in a single-entry
// output register and hands it to decode with valid/ready. id_imm is the low
// half of the registered instruction and feeds the immediate extender.
// A redirect pulse flushes the output register and any in-flight fetch and
// restarts fetching at the redirect target.
//
// Optional feature, macro IFU_ALIGN_CHECK_EN:
//   defined   - adds output fetch_err; a redirect to a non-word-aligned target
//               sets fetch_err (sticky), keeps the PC and parks the unit in
//               HALT until reset.
//   undefined - no fetch_err port; the low two target bits are ignored.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  ifu_fetch_if.master bus
`ifdef IFU_ALIGN_CHECK_EN
  ,
  output logic        fetch_err
`endif
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_discard;
  logic        w_nextDiscard;
  logic [31:0] r_pc;
  logic [31:0] r_fetchAddr;
  logic        r_idValid;
  logic [31:0] r_idInstr;
  logic [31:0] r_idPc;

  logic        w_badTarget;
  logic        w_redirectOk;
  logic        w_req;
  logic        w_accept;
  logic        w_load;
  logic        w_transfer;
  logic [31:0] w_targetWord;

`ifdef IFU_ALIGN_CHECK_EN
  logic        r_fetchErr;

  assign w_badTarget = bus.redirect && (bus.redirect_target[1:0] != 2'b00);
  assign fetch_err   = r_fetchErr;
`else
  logic [1:0]  w_unusedTargetLow;

  assign w_badTarget       = 1'b0;
  assign w_unusedTargetLow = bus.redirect_target[1:0];
`endif

  // a well-formed redirect moves the PC; once halted nothing but reset matters
  assign w_redirectOk = bus.redirect && !w_badTarget && (r_state != ST_HALT);
  assign w_targetWord = {bus.redirect_target[31:2], 2'b00};

  // request only when the output register can take the result; a redirect
  // cycle never requests so the old PC can never be accepted
  assign w_req      = (r_state == ST_REQ) && !bus.redirect && (!r_idValid || bus.id_ready);
  assign w_accept   = w_req && bus.imem_gnt;
  assign w_load     = (r_state == ST_WAIT) && bus.imem_rvalid && !r_discard && !bus.redirect;
  assign w_transfer = r_idValid && bus.id_ready;

  assign bus.imem_req  = reset && w_req;
  assign bus.imem_addr = r_pc;
  assign bus.id_valid  = r_idValid;
  assign bus.id_instr  = r_idInstr;
  assign bus.id_pc     = r_idPc;
  assign bus.id_imm    = r_idInstr[15:0];

  // next-state and discard flag: a redirect during WAIT marks the in-flight
  // response as stale unless that response is arriving in the same cycle
  always_comb begin
    w_nextState   = r_state;
    w_nextDiscard = r_discard;
    case (r_state)
      ST_REQ: begin
        if (w_badTarget) begin
          w_nextState = ST_HALT;
        end else if (w_accept) begin
          w_nextState = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_badTarget) begin
          w_nextState   = ST_HALT;
          w_nextDiscard = 1'b0;
        end else if (bus.redirect) begin
          if (bus.imem_rvalid) begin
            w_nextState   = ST_REQ;
            w_nextDiscard = 1'b0;
          end else begin
            w_nextDiscard = 1'b1;
          end
        end else if (bus.imem_rvalid) begin
          w_nextState   = ST_REQ;
          w_nextDiscard = 1'b0;
        end
      end
      ST_HALT: begin
        w_nextDiscard = 1'b0;
      end
      default: begin
        w_nextState   = ST_REQ;
        w_nextDiscard = 1'b0;
      end
    endcase
  end

  // FSM state and stale-response flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_REQ;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_discard <= w_nextDiscard;
    end
  end

  // PC: redirect wins over the sequential advance; remember each accepted address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_PC;
      r_fetchAddr <= 32'h0000_0000;
    end else begin
      if (w_redirectOk) begin
        r_pc <= w_targetWord;
      end else if (w_accept) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_accept) begin
        r_fetchAddr <= r_pc;
      end
    end
  end

  // output register: flush on redirect, load on a live response, drain on transfer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idValid <= 1'b0;
      r_idInstr <= 32'h0000_0000;
      r_idPc    <= 32'h0000_0000;
    end else begin
      if (bus.redirect || (r_state == ST_HALT)) begin
        r_idValid <= 1'b0;
      end else if (w_load) begin
        r_idValid <= 1'b1;
        r_idInstr <= bus.imem_rdata;
        r_idPc    <= r_fetchAddr;
      end else if (w_transfer) begin
        r_idValid <= 1'b0;
      end
    end
  end

`ifdef IFU_ALIGN_CHECK_EN
  // sticky alignment error, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetchErr <= 1'b0;
    end else if (w_badTarget) begin
      r_fetchErr <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed scenarios plus a randomized run of ifu_fetch against
// a transaction-level reference model (PC, one in-flight fetch with a kill
// flag, one held decode entry) and a simple instruction memory whose words
// are the address XOR a fixed key.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] MEM_KEY  = 32'h5A5A_C3C3;

  logic clk;
  logic reset;
`ifdef IFU_ALIGN_CHECK_EN
  logic fetch_err;
`endif

  int nCompared = 0;
  int nFailed   = 0;

  // reference model state
  logic [31:0] mPc;
  logic [31:0] mFa;
  logic [31:0] mHoldPc;
  logic [31:0] mHoldInstr;
  logic        mHoldValid;
  logic        mOut;
  logic        mKill;
  int          mCnt;

  ifu_fetch_if bus ();

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IFU_ALIGN_CHECK_EN
    ,
    .fetch_err (fetch_err)
`endif
  );

  // free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return addr ^ MEM_KEY;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nFailed++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    reset                 = 1'b0;
    bus.imem_gnt          = 1'b1;
    bus.id_ready          = 1'b1;
    bus.imem_rvalid       = 1'b0;
    bus.imem_rdata        = 32'h0;
    bus.redirect          = 1'b0;
    bus.redirect_target   = 32'h0;
    #1;
    checkOutput("reset_req", 32'(bus.imem_req), 32'd0);
    checkOutput("reset_valid", 32'(bus.id_valid), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("reset_pc", bus.imem_addr, RESET_PC);
    checkOutput("reset_id_pc", bus.id_pc, 32'h0);
    checkOutput("reset_id_instr", bus.id_instr, 32'h0);
    mPc        = RESET_PC;
    mFa        = 32'h0;
    mHoldPc    = 32'h0;
    mHoldInstr = 32'h0;
    mHoldValid = 1'b0;
    mOut       = 1'b0;
    mKill      = 1'b0;
    mCnt       = 0;
    reset      = 1'b1;
  endtask

  // One clock cycle: drive inputs just after a falling edge, compare outputs
  // against the model, advance the model, then move to the next falling edge.
  // lat is the response latency used if a fetch is accepted in this cycle.
  task automatic applyStimulus(input bit gnt, input bit ready, input bit redir,
                               input logic [31:0] tgt, input int lat);
    bit rv;
    bit expReq;
    bit acc;
    bit load;
    bit newValid;

    rv = mOut && (mCnt == 0);
    bus.imem_gnt        = gnt;
    bus.imem_rvalid     = rv;
    bus.imem_rdata      = rv ? memWord(mFa) : $urandom;
    bus.id_ready        = ready;
    bus.redirect        = redir;
    bus.redirect_target = tgt;
    #1;

    expReq = !mOut && !redir && (!mHoldValid || ready);
    checkOutput("imem_req", 32'(bus.imem_req), 32'(expReq));
    if (expReq) checkOutput("imem_addr", bus.imem_addr, mPc);
    checkOutput("id_valid", 32'(bus.id_valid), 32'(mHoldValid));
    checkOutput("id_pc", bus.id_pc, mHoldPc);
    checkOutput("id_instr", bus.id_instr, mHoldInstr);
    checkOutput("id_imm", 32'(bus.id_imm), {16'h0, mHoldInstr[15:0]});

    acc  = expReq && gnt;
    load = rv && !mKill && !redir;

    if (load) newValid = 1'b1;
    else if (mHoldValid && ready) newValid = 1'b0;
    else newValid = mHoldValid;
    if (redir) newValid = 1'b0;
    if (load) begin
      mHoldPc    = mFa;
      mHoldInstr = memWord(mFa);
    end
    mHoldValid = newValid;

    if (mOut) begin
      if (rv) begin
        mOut  = 1'b0;
        mKill = 1'b0;
      end else begin
        mCnt--;
        if (redir) mKill = 1'b1;
      end
    end else if (acc) begin
      mFa  = mPc;
      mOut = 1'b1;
      mCnt = lat - 1;
    end

    if (redir) mPc = {tgt[31:2], 2'b00};
    else if (acc) mPc = mPc + 32'd4;

    @(negedge clk);
  endtask

  initial begin
    resetDut();

    // streaming with zero-wait memory: one instruction every two cycles
    for (int i = 0; i < 7; i++) begin
      if (i == 2 || i == 4 || i == 6) begin
        checkOutput("stream_valid", 32'(bus.id_valid), 32'd1);
        checkOutput("stream_pc", bus.id_pc, RESET_PC + 32'(2 * (i - 2)));
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
    end

    // decode backpressure holds the entry and the PC
    resetDut();
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1);
    checkOutput("stall_pc", bus.id_pc, 32'h0000_3000);
    checkOutput("stall_valid", 32'(bus.id_valid), 32'd1);
    checkOutput("stall_fetch_addr", bus.imem_addr, 32'h0000_3004);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
    checkOutput("resume_pc", bus.id_pc, 32'h0000_3004);

    // redirect while waiting, stale response three cycles later
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 4);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_3100, 1);
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
    checkOutput("redir_wait_valid", 32'(bus.id_valid), 32'd1);
    checkOutput("redir_wait_pc", bus.id_pc, 32'h0000_3100);
    checkOutput("redir_wait_instr", bus.id_instr, 32'h0000_3100 ^ MEM_KEY);

    // redirect in the same cycle as the response
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_3100, 1);
    checkOutput("redir_rv_addr", bus.imem_addr, 32'h0000_3100);
    checkOutput("redir_rv_valid", 32'(bus.id_valid), 32'd0);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
    checkOutput("redir_rv_pc", bus.id_pc, 32'h0000_3100);

    // PC wraps from the top word to zero
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
    checkOutput("wrap_top_pc", bus.id_pc, 32'hFFFF_FFFC);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
    checkOutput("wrap_zero_pc", bus.id_pc, 32'h0000_0000);
    checkOutput("wrap_zero_valid", 32'(bus.id_valid), 32'd1);

`ifdef IFU_ALIGN_CHECK_EN
    // misaligned redirect halts the unit until reset
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 2);
    bus.redirect        = 1'b1;
    bus.redirect_target = 32'h0000_3102;
    bus.imem_rvalid     = 1'b0;
    @(negedge clk);
    bus.redirect    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = memWord(32'h0000_3000);
    #1;
    checkOutput("halt_err", 32'(fetch_err), 32'd1);
    checkOutput("halt_req", 32'(bus.imem_req), 32'd0);
    checkOutput("halt_valid", 32'(bus.id_valid), 32'd0);
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    #1;
    checkOutput("halt_req_hold", 32'(bus.imem_req), 32'd0);
    checkOutput("halt_valid_hold", 32'(bus.id_valid), 32'd0);
    checkOutput("halt_pc_kept", bus.imem_addr, 32'h0000_3004);
    @(negedge clk);
    resetDut();
    checkOutput("halt_err_cleared", 32'(fetch_err), 32'd0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
    checkOutput("halt_restart_pc", bus.id_pc, RESET_PC);
`else
    // low target bits are ignored
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_3103, 1);
    checkOutput("unaligned_ignored_addr", bus.imem_addr, 32'h0000_3100);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
    checkOutput("unaligned_ignored_pc", bus.id_pc, 32'h0000_3100);
`endif

    // randomized traffic with a reset dropped in mid-run
    resetDut();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) resetDut();
      applyStimulus(($urandom_range(99, 0) < 75),
                    ($urandom_range(99, 0) < 70),
                    ($urandom_range(99, 0) < 5),
                    $urandom & 32'hFFFF_FFFC,
                    int'($urandom_range(3, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
